// File: rtl/ca6_pkg.sv
// ca6_pkg: shared definitions for the ca6 Taylor-series sine block.
//   - state_t   : controller FSM state encoding
//   - FRAC      : fractional bits of the Q8.8 datapath
//   - CFRAC     : fractional bits of the Q0.16 coefficient ROM
//   - C1..C3    : 1/3!, 1/(4*5), 1/(6*7) as Q0.16 magnitudes
//   - coef_rom  : term index k (1..3) -> coefficient
package ca6_pkg;

    localparam int N_TERMS_DEF = 4;
    localparam int W_DEF       = 16;
    localparam int FRAC        = 8;
    localparam int CFRAC       = 16;

    localparam logic [15:0] C1 = 16'h2AAB;  // 1/6
    localparam logic [15:0] C2 = 16'h0CCD;  // 1/20
    localparam logic [15:0] C3 = 16'h0618;  // 1/42

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SQR  = 3'd2,
        S_MUL  = 3'd3,
        S_SCL  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Each coefficient already folds in the two new factorial factors, so
    // term_k = -term_(k-1) * x^2 * c_k stays a single multiply per stage.
    function automatic logic [15:0] coef_rom(input logic [1:0] k);
        logic [15:0] c;
        case (k)
            2'd1:    c = C1;
            2'd2:    c = C2;
            2'd3:    c = C3;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ca6_datapath.sv
// ca6_datapath: registers, shared signed multiplier, coefficient ROM and
// accumulator for the Taylor-series sine.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   state      : controller state, selects multiplier operands and updates
//   x          : Q8.8 angle, captured in LOAD
//   in_y       : Q0.8 bias, folded into the accumulator in LOAD
//   k_last     : high while the stage index is on the final term
//   out_ans    : Q8.8 result, written when the final term is accumulated
module ca6_datapath
    import ca6_pkg::*;
#(
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int W       = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  state_t       state,
    input  logic [W-1:0] x,
    input  logic [7:0]   in_y,
    output logic         k_last,
    output logic [W-1:0] out_ans
);

    localparam logic [1:0] K_LAST = 2'(N_TERMS - 1);

    logic signed [W-1:0]   x_r;
    logic signed [W-1:0]   x2;
    logic signed [W-1:0]   term;
    logic signed [W-1:0]   acc;
    logic [1:0]            k;

    logic signed [W-1:0]   mul_a;
    logic signed [W-1:0]   mul_b;
    logic signed [2*W-1:0] prod;
    logic signed [W-1:0]   res;

    // One multiplier serves all three product kinds; the operand pair is
    // chosen by the stage the controller is in.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_SQR: begin
                mul_a = x_r;
                mul_b = x_r;
            end
            S_MUL: begin
                mul_a = term;
                mul_b = x2;
            end
            S_SCL: begin
                mul_a = term;
                mul_b = W'($signed(coef_rom(k)));
            end
            default: ;
        endcase
    end

    assign prod = mul_a * mul_b;

    // Truncating arithmetic shift back to Q8.8; no rounding.
    always_comb begin
        if (state == S_SCL) begin
            res = W'(prod >>> CFRAC);
        end else begin
            res = W'(prod >>> FRAC);
        end
    end

    assign k_last = (k == K_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= '0;
            x2      <= '0;
            term    <= '0;
            acc     <= '0;
            k       <= '0;
            out_ans <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    x_r  <= x;
                    term <= x;
                    acc  <= x + {{(W-8){in_y[7]}}, in_y};
                    k    <= 2'd1;
                end
                S_SQR: begin
                    x2 <= res;
                end
                S_MUL: begin
                    term <= res;
                end
                S_SCL: begin
                    // Sign alternates every stage, so the new term is the
                    // negated scaled product and the accumulator subtracts it.
                    term <= -res;
                    acc  <= acc - res;
                    k    <= k + 2'd1;
                    if (k == K_LAST) begin
                        out_ans <= acc - res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ca6_sine_taylor.sv
// ca6_sine_taylor: iterative 4-term Taylor sine, out_ans = sin(x) + in_y.
// Ports:
//   start   : level request, sampled only in IDLE
//   clk     : clock, rising edge
//   x       : Q8.8 signed angle in radians, |x| <= pi (0x0324)
//   in_y    : Q0.8 signed bias added to the result
//   out_ans : Q8.8 signed result, held between computations
//   done    : result valid, held until start is seen low
//   rst_n   : asynchronous active-low reset
// Handshake: start is a level; one computation runs per start assertion,
// done stays high until start drops, and only then can a new start be seen.
module ca6_sine_taylor
    import ca6_pkg::*;
#(
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int W       = W_DEF
) (
    input  logic         start,
    input  logic         clk,
    input  logic [W-1:0] x,
    input  logic [7:0]   in_y,
    output logic [W-1:0] out_ans,
    output logic         done,
    input  logic         rst_n
);

    // Controller state, kept as a named signal for observation.
    state_t state;
    logic   k_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: state <= S_SQR;
                S_SQR:  state <= S_MUL;
                S_MUL:  state <= S_SCL;
                S_SCL: begin
                    if (k_last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_MUL;
                    end
                end
                S_DONE: begin
                    // A held start keeps us here, so it cannot retrigger.
                    if (!start) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    ca6_datapath #(
        .N_TERMS (N_TERMS),
        .W       (W)
    ) u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .state   (state),
        .x       (x),
        .in_y    (in_y),
        .k_last  (k_last),
        .out_ans (out_ans)
    );

endmodule

// File: tb/tb_ca6_sine_taylor.sv
module tb_ca6_sine_taylor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] x_i;
  logic [7:0]  y_i;
  logic [15:0] out_ans;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_rises = 0;
  int n_runs = 0;
  logic cmp_en = 1'b0;
  logic prev_done = 1'b0;
  logic        exp_done = 1'b0;
  logic [15:0] exp_ans = 16'h0000;
  logic [15:0] exp_q[$];

  ca6_sine_taylor dut (
    .start   (start),
    .clk     (clk),
    .x       (x_i),
    .in_y    (y_i),
    .out_ans (out_ans),
    .done    (done),
    .rst_n   (rst_n)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic longint wrap16(input longint v);
    logic [15:0] b;
    b = v[15:0];
    return longint'($signed(b));
  endfunction

  // sin(x) ~ x - x^3/6 + x^5/120 - x^7/5040 built term by term with the
  // coefficient ratios 1/6, 1/20, 1/42, every product truncated to 16 bits.
  function automatic logic [15:0] sine_model(input logic [15:0] xv, input logic [7:0] yv);
    longint c [3];
    longint xs, x2, term, acc, t;
    logic [15:0] r;
    c[0] = 10923; c[1] = 3277; c[2] = 1560;
    xs   = longint'($signed(xv));
    x2   = wrap16((xs * xs) >>> 8);
    term = xs;
    acc  = wrap16(xs + longint'($signed(yv)));
    for (int i = 0; i < 3; i++) begin
      t    = wrap16((term * x2) >>> 8);
      t    = wrap16((t * c[i]) >>> 16);
      term = wrap16(-t);
      acc  = wrap16(acc + term);
    end
    r = acc[15:0];
    return r;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check_eq(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic check_tol(input string name, input logic [15:0] got, input logic [15:0] want, input int tol);
    int d;
    d = int'($signed(got)) - int'($signed(want));
    checks++;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got %h expected %h +/-%0d", name, got, want, tol);
    end
  endtask

  // ---------------- cycle compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL cyc_done @%0t: got %b expected %b", $time, done, exp_done);
      end
      checks++;
      if (out_ans !== exp_ans) begin
        errors++;
        $display("FAIL cyc_ans @%0t: got %h expected %h", $time, out_ans, exp_ans);
      end
      if (done === 1'b1 && prev_done === 1'b0) done_rises++;
    end
    prev_done = done;
  end

  // ---------------- driver ----------------
  // Edge 1 is the rising edge that samples start in IDLE; done must be
  // visible after edge 9 and must drop on the first edge that sees start low.
  task automatic run(input logic [15:0] xv, input logic [7:0] yv, input int hold);
    int held;
    @(negedge clk);
    x_i = xv;
    y_i = yv;
    start = 1'b1;
    held = 1;
    exp_q.push_back(sine_model(xv, yv));
    n_runs++;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e == 9) begin
        exp_done = 1'b1;
        exp_ans  = exp_q.pop_front();
      end else if (e > 9 && start == 1'b0) begin
        exp_done = 1'b0;
        break;
      end
      @(negedge clk);
      // Inputs are garbage once captured; the result must not notice.
      if (e >= 2) begin
        x_i = 16'($urandom);
        y_i = 8'($urandom);
      end
      if (held >= hold) start = 1'b0;
      else held++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x_i   = 16'h0000;
    y_i   = 8'h00;
    #12;
    check_eq("reset_done", {15'd0, done}, 16'h0000);
    check_eq("reset_ans", out_ans, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Pin the model with hand-worked values.
    check_eq("model_pi5", sine_model(16'h00A0, 8'h00), 16'h0097);
    check_eq("model_pi", sine_model(16'h0324, 8'h00), 16'hFFEE);
    check_eq("model_npi5", sine_model(16'hFF60, 8'h00), 16'hFF6B);
    check_eq("model_bias", sine_model(16'h00A0, 8'h40), 16'h00D7);

    run(16'h00A0, 8'h00, 2);  check_tol("sin_pi5", out_ans, 16'h0095, 2);
    run(16'h0191, 8'h00, 3);  check_tol("sin_pi2", out_ans, 16'h0100, 2);
    run(16'h00C8, 8'h00, 1);  check_tol("sin_pi4", out_ans, 16'h00B4, 2);
    run(16'h010C, 8'h00, 4);  check_tol("sin_pi3", out_ans, 16'h00DD, 2);
    run(16'h0324, 8'h00, 2);  check_tol("sin_pi", out_ans, 16'hFFED, 3);
    run(16'hFF60, 8'h00, 2);  check_tol("sin_npi5", out_ans, 16'hFF6B, 2);
    run(16'h00A0, 8'h40, 20); check_tol("sin_bias_hold20", out_ans, 16'h00D5, 2);

    // Reset in the middle of a computation (state MUL after edge 3).
    @(negedge clk);
    x_i = 16'h00C8;
    y_i = 8'h00;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    exp_done = 1'b0;
    exp_ans = 16'h0000;
    #1;
    check_eq("rst_mid_done", {15'd0, done}, 16'h0000);
    check_eq("rst_mid_ans", out_ans, 16'h0000);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    run(16'h010C, 8'h00, 2);  check_tol("after_reset_pi3", out_ans, 16'h00DD, 2);
    run(16'h0000, 8'hC0, 2);  check_eq("zero_neg_bias", out_ans, 16'hFFC0);

    repeat (3) @(negedge clk);
    check_eq("done_rise_count", 16'(done_rises), 16'(n_runs));
    check_eq("exp_q_empty", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ca6_sine_taylor.md
CA6_SINE_TAYLOR -- requirements
Module: ca6

Interface
REQ-001 The port clk SHALL be a 1-bit input, the single clock; all state updates occur on its rising edge.
REQ-002 The port rst_n SHALL be a 1-bit input: asynchronous, active-low reset.
REQ-003 The port start SHALL be a 1-bit input: level request to begin a computation, sampled only in IDLE.
REQ-004 The port x SHALL be a 16-bit input: signed two's-complement angle in radians, Q8.8 (pi = 0x0324), valid range |x| <= 0x0324.
REQ-005 The port in_y SHALL be an 8-bit input: signed Q0.8 bias added to the result (0 gives plain sin).
REQ-006 The port out_ans SHALL be a 16-bit output: signed Q8.8 result, sin(x) + in_y.
REQ-007 The port done SHALL be a 1-bit output: result valid.
REQ-008 Ports SHALL be declared in the order start, clk, x, in_y, out_ans, done, rst_n, so positional instantiations of the first six ports remain valid.
REQ-009 Parameters: N_TERMS = 4 (number of Taylor terms); W = 16 (datapath width).

Function
REQ-010 The result SHALL be sin(x) = x - x^3/3! + x^5/5! - x^7/7!, computed iteratively as term_k = -term_(k-1) * x2 * c_k, with term_0 = x.
REQ-011 x2 SHALL be (x*x) >>> 8, a 32-bit signed product truncated to Q8.8.
REQ-012 The coefficient ROM SHALL hold Q0.16 values: c1 = 1/6 = 0x2AAB, c2 = 1/20 = 0x0CCD, c3 = 1/42 = 0x0618.
REQ-013 Each product SHALL be a full 32-bit signed product, arithmetic-shifted right (8 for Q8.8 operands, 16 for c_k) and truncated to 16 bits, with no rounding.
REQ-014 The accumulator SHALL be 16-bit signed and initialised to x + sign_extend(in_y); wrap-around on overflow is accepted with no saturation.
REQ-015 FSM states and transitions:
- IDLE -> LOAD when start = 1.
- LOAD: latch x and in_y; term = x; acc init; k = 1.
- SQR: compute x2.
- MUL: term = term*x2.
- SCL: term = -(term*c_k); acc += term; k++.
- SCL returns to MUL while k <= 3, else goes to DONE.
- DONE -> IDLE when start = 0.
REQ-016 Latency: done SHALL rise on the 9th rising edge after the edge that sampled start (LOAD, SQR, 3 x (MUL, SCL), then DONE).
REQ-017 done SHALL be 1 only in DONE, and SHALL be held until start is low.
REQ-018 out_ans SHALL hold the last completed result in every state other than LOAD, and SHALL update only on entry to DONE.
REQ-019 Changes to x or in_y after LOAD SHALL NOT affect the running computation.
REQ-020 A start held high through a whole computation SHALL produce exactly one computation; no restart occurs until start has been seen low in DONE.

Reset
REQ-021 When rst_n = 0, the block SHALL immediately (asynchronously) force state = IDLE, done = 0, out_ans = 0x0000, and clear all internal registers, including mid-computation.
REQ-022 After rst_n returns to 1, the block SHALL wait in IDLE for start.

Structure
REQ-023 A package ca6_pkg SHALL hold the FSM state enum, the Q-format constants (FRAC = 8), and the coefficient ROM constants.
REQ-024 The block SHALL be split into one controller FSM and one datapath sub-module, ca6_datapath (registers, one shared 16x16 signed multiplier, ROM, accumulator).

Verification
REQ-025 x = 0x00A0 (pi/5), in_y = 0, start high for 2 cycles -> out_ans = 0x0095 +/-2 LSB, with done high at edge 9.
REQ-026 x = 0x0191 (pi/2) -> out_ans = 0x0100 +/-2; x = 0x00C8 (pi/4) -> 0x00B4 +/-2; x = 0x010C (pi/3) -> 0x00DD +/-2.
REQ-027 x = 0x0324 (pi) -> out_ans = 0xFFED +/-3 (4-term truncation error, negative); x = 0xFF60 (-pi/5) -> 0xFF6B +/-2.
REQ-028 x = 0x00A0, in_y = 0x40 -> out_ans = 0x00D5 +/-2.
REQ-029 Assert rst_n low during MUL -> done = 0 and out_ans = 0 at once; the next start computes correctly.
REQ-030 Hold start high for 20 cycles -> exactly one done assertion, with done held until start falls.
